bin_to_gray: RTL and testbench

- Converts a 4-bit binary code, presented as four scalar bits a (MSB), b, c, d (LSB), into 4-bit reflected Gray code.
- Provides an immediate combinational result and a registered result with a valid flag.
- Used as a leaf converter ahead of counters or pointers that cross clock domains.
- Single clock domain; asynchronous active-high reset.

---
 rtl/bin_to_gray.sv | 76 +++++++
 tb/tb_bin_to_gray.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_gray.sv
// 4-bit binary to reflected Gray converter: combinational gry plus a PIPE_STAGES-deep registered gry_q/out_valid.
// Optional BIN_TO_GRAY_CHECK_EN adds a Gray-to-binary self-check (bin_chk, chk_err) on the last stage.
module bin_to_gray #(
   parameter int PIPE_STAGES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       in_valid,
   output logic [3:0] gry,
   output logic [3:0] gry_q,
   output logic       out_valid
`ifdef BIN_TO_GRAY_CHECK_EN
   ,
   output logic [3:0] bin_chk,
   output logic       chk_err
`endif
);

   if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
      $error("bin_to_gray: PIPE_STAGES must be 1 or 2");
   end

   assign gry = {a, a ^ b, b ^ c, c ^ d};

`ifdef BIN_TO_GRAY_CHECK_EN
   // The binary input travels alongside its Gray code so the last stage can be cross-checked.
   localparam int W = 8;
   logic [W-1:0] payload;
   assign payload = {a, b, c, d, gry};
`else
   localparam int W = 4;
   logic [W-1:0] payload;
   assign payload = gry;
`endif

   logic [PIPE_STAGES-1:0][W-1:0] data_pipe;
   logic [PIPE_STAGES-1:0]        vld_pipe;
   logic [W-1:0]                  last_stage;

   // NOTE: data registers are reset too (not just the valid bits), so gry_q reads 0000 the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_pipe <= '0;
         vld_pipe  <= '0;
      end else begin
         vld_pipe[0] <= in_valid;
         if (in_valid) data_pipe[0] <= payload;
         for (int s = 1; s < PIPE_STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
         end
      end
   end

   assign last_stage = data_pipe[PIPE_STAGES-1];
   assign gry_q      = last_stage[3:0];
   assign out_valid  = vld_pipe[PIPE_STAGES-1];

`ifdef BIN_TO_GRAY_CHECK_EN
   // Binary bit i is the XOR of Gray bits i and above.
   // NOTE: combinational outputs get a default before the loop so no latch can be inferred.
   always_comb begin
      bin_chk = '0;
      for (int i = 0; i < 4; i++) begin
         bin_chk[i] = ^(last_stage[3:0] >> i);
      end
   end

   assign chk_err = out_valid && (bin_chk != last_stage[7:4]);
`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// Self-checking bench for bin_to_gray: PIPE_STAGES=1 and =2 instances driven in parallel and compared
// every cycle against a cycle-history reference model, plus literal spot checks.
module tb_bin_to_gray;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic in_valid = 1'b0;
   logic [3:0] gry1, gry2, gq1, gq2;
   logic ov1, ov2;
`ifdef BIN_TO_GRAY_CHECK_EN
   logic [3:0] bc1, bc2;
   logic ce1, ce2;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bin_to_gray #(.PIPE_STAGES(1)) dut1 (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
      .gry(gry1), .gry_q(gq1), .out_valid(ov1)
`ifdef BIN_TO_GRAY_CHECK_EN
      , .bin_chk(bc1), .chk_err(ce1)
`endif
   );

   bin_to_gray #(.PIPE_STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
      .gry(gry2), .gry_q(gq2), .out_valid(ov2)
`ifdef BIN_TO_GRAY_CHECK_EN
      , .bin_chk(bc2), .chk_err(ce2)
`endif
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] gray_of(input logic [3:0] x);
      return x ^ (x >> 1);
   endfunction

   // Reference model: remember what was presented on every accepted edge; the output after edge n
   // is the item presented at edge n-P+1, unless a reset happened since.
   int cyc = 0;
   int base = 1;
   int idx;
   bit hv[0:16383];
   logic [3:0] hb[0:16383];
   bit m_v[1:2] = '{0, 0};
   logic [3:0] m_q[1:2] = '{4'h0, 4'h0};
   logic [3:0] m_b[1:2] = '{4'h0, 4'h0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         base = cyc + 1;
         for (int p = 1; p <= 2; p++) begin
            m_v[p] = 0;
            m_q[p] = 4'h0;
            m_b[p] = 4'h0;
         end
      end else begin
         cyc++;
         hv[cyc] = in_valid;
         hb[cyc] = {a, b, c, d};
         for (int p = 1; p <= 2; p++) begin
            idx = cyc - p + 1;
            m_v[p] = (idx >= base) && hv[idx];
            if (m_v[p]) begin
               m_q[p] = gray_of(hb[idx]);
               m_b[p] = hb[idx];
            end
         end
      end
   end

   always @(negedge clk) begin
      check("gry_comb_p1", {4'h0, gry1}, {4'h0, gray_of({a, b, c, d})});
      check("gry_comb_p2", {4'h0, gry2}, {4'h0, gray_of({a, b, c, d})});
      check("gry_q_p1", {4'h0, gq1}, {4'h0, m_q[1]});
      check("out_valid_p1", {7'h0, ov1}, {7'h0, m_v[1]});
      check("gry_q_p2", {4'h0, gq2}, {4'h0, m_q[2]});
      check("out_valid_p2", {7'h0, ov2}, {7'h0, m_v[2]});
`ifdef BIN_TO_GRAY_CHECK_EN
      check("bin_chk_p1", {4'h0, bc1}, {4'h0, m_b[1]});
      check("bin_chk_p2", {4'h0, bc2}, {4'h0, m_b[2]});
      check("chk_err_p1", {7'h0, ce1}, 8'h00);
      check("chk_err_p2", {7'h0, ce2}, 8'h00);
`endif
   end

   task automatic step(input logic [3:0] x, input logic v);
      @(posedge clk);
      #2;
      {a, b, c, d} = x;
      in_valid = v;
   endtask

   logic [3:0] sweep_in[7]  = '{4'b0000, 4'b0001, 4'b1100, 4'b0101, 4'b1010, 4'b0011, 4'b1111};
   logic [3:0] sweep_out[7] = '{4'b0000, 4'b0001, 4'b1010, 4'b0111, 4'b1111, 4'b0010, 4'b1000};
   logic [3:0] gray_lut[16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
   logic [3:0] prev_q;

   initial begin
      #1 rst = 1'b1;
      #1;
      // Combinational sweep every 5 ns, first under reset, then with reset released.
      for (int i = 0; i < 7; i++) begin
         if (i == 4) rst = 1'b0;
         {a, b, c, d} = sweep_in[i];
         #1;
         check("sweep_gry_p1", {4'h0, gry1}, {4'h0, sweep_out[i]});
         check("sweep_gry_p2", {4'h0, gry2}, {4'h0, sweep_out[i]});
         #4;
      end

      // Exhaustive 0..15 back-to-back, PIPE_STAGES=1.
      for (int i = 0; i <= 16; i++) begin
         step(i[3:0], i < 16);
         if (i >= 1) begin
            check("exh_gry_q", {4'h0, gq1}, {4'h0, gray_lut[i-1]});
            check("exh_out_valid", {7'h0, ov1}, 8'h01);
            if (i >= 2) check("exh_one_bit_step", 8'($countones(gq1 ^ prev_q)), 8'h01);
            prev_q = gq1;
         end
      end
      step(4'h0, 1'b0);
      check("exh_valid_drop", {7'h0, ov1}, 8'h00);
      check("exh_hold", {4'h0, gq1}, 8'h08);

      // PIPE_STAGES=2 back-to-back.
      step(4'b0101, 1'b1);
      step(4'b1010, 1'b1);
      step(4'b0011, 1'b1);
      check("p2_first", {3'h0, ov2, gq2}, 8'b0001_0111);
      step(4'b0000, 1'b0);
      check("p2_second", {3'h0, ov2, gq2}, 8'b0001_1111);
      step(4'b0000, 1'b0);
      check("p2_third", {3'h0, ov2, gq2}, 8'b0001_0010);
      step(4'b0000, 1'b0);
      check("p2_done", {3'h0, ov2, gq2}, 8'b0000_0010);

      // in_valid gap: gry_q holds.
      step(4'b1100, 1'b1);
      step(4'b1111, 1'b0);
      check("gap_loaded", {3'h0, ov1, gq1}, 8'b0001_1010);
      step(4'b1111, 1'b0);
      check("gap_hold", {3'h0, ov1, gq1}, 8'b0000_1010);
      check("gap_comb", {4'h0, gry1}, 8'b0000_1000);

      // Asynchronous reset with items in flight.
      step(4'b0101, 1'b1);
      step(4'b1010, 1'b1);
      #1 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_p1", {3'h0, ov1, gq1}, 8'h00);
      check("rst_p2", {3'h0, ov2, gq2}, 8'h00);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      step(4'b0000, 1'b0);
      check("rel_stale_p1", {7'h0, ov1}, 8'h00);
      check("rel_stale_p2a", {7'h0, ov2}, 8'h00);
      step(4'b0000, 1'b1);
      check("rel_stale_p2b", {7'h0, ov2}, 8'h00);
      step(4'b0000, 1'b0);
      check("rel_zero_p1", {3'h0, ov1, gq1}, 8'b0001_0000);
      step(4'b0000, 1'b0);
      check("rel_zero_p2", {3'h0, ov2, gq2}, 8'b0001_0000);

`ifdef BIN_TO_GRAY_CHECK_EN
      // Corrupt one Gray bit in the last stage: chk_err must fire.
      step(4'b0110, 1'b1);
      step(4'b0000, 1'b0);
      check("chk_pre", {3'h0, ov1, gq1}, 8'b0001_0101);
      force dut1.data_pipe = {4'b0110, 4'b0100};
      #1;
      check("chk_err_forced", {7'h0, ce1}, 8'h01);
      force dut1.data_pipe = {4'b0110, 4'b0101};
      #1;
      release dut1.data_pipe;
      #1;
      check("chk_err_restored", {7'h0, ce1}, 8'h00);
      step(4'b0000, 1'b0);
      check("chk_err_next", {7'h0, ce1}, 8'h00);
`endif

      // Randomized traffic with one mid-run asynchronous reset.
      for (int i = 0; i < 300; i++) begin
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (i == 150) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      step(4'h0, 1'b0);
      step(4'h0, 1'b0);
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
